// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: 2-bit counter encoding, sweep FSM states
// and the saturating counter update.
package branch_predictor_pkg;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t CTR_SNT = 2'b00;
    localparam bp_ctr_t CTR_WNT = 2'b01;
    localparam bp_ctr_t CTR_WT  = 2'b10;
    localparam bp_ctr_t CTR_ST  = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_t;

    // Counters saturate at SNT and ST; they never wrap.
    function automatic bp_ctr_t bp_ctr_next(bp_ctr_t c, logic t);
        bp_ctr_t n;
        n = c;
        if (t && c != CTR_ST)
            n = c + 2'd1;
        else if (!t && c != CTR_SNT)
            n = c - 2'd1;
        return n;
    endfunction

endpackage

// File: rtl/branch_predictor_pht.sv
// Pattern history table: 2^PHT_BITS counters, one registered read-first read port
// and one write port that either initialises an entry or trains it in place.
module bp_pht
    import branch_predictor_pkg::*;
#(
    parameter int PHT_BITS = 10
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                rd_en,
    input  logic [PHT_BITS-1:0] rd_idx,
    output bp_ctr_t             rd_data,
    input  logic                wr_en,
    input  logic                wr_init,
    input  logic [PHT_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    bp_ctr_t mem [2**PHT_BITS];

    // Training is applied to the stored value in the same cycle, so consecutive
    // updates to one entry always build on each other.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= wr_init ? CTR_WNT : bp_ctr_next(mem[wr_idx], wr_taken);
    end

    // Non-blocking read returns the pre-write value on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (!rstn)
            rd_data <= CTR_SNT;
        else if (rd_en)
            rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal / gshare conditional branch predictor with a post-reset table sweep.
// Define BP_GSHARE_EN to hash the fetch PC with global history.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int PHT_BITS = 10,
    parameter int GHR_BITS = 10
) (
    input  logic                clk,
    input  logic                rstn,
    output logic                ready,
    input  logic                lookup_en,
    input  logic [31:0]         lookup_pc,
    output logic                pred_valid,
    output logic                prediction,
    output logic [PHT_BITS-1:0] pred_idx,
    input  logic                update,
    input  logic                taken,
    input  logic [PHT_BITS-1:0] update_idx,
    output bp_state_t           dbg_state
);

    bp_state_t             state;
    logic [PHT_BITS-1:0]   ptr;
    logic [PHT_BITS-1:0]   lookup_idx;
    logic                  run;
    bp_ctr_t               rd_ctr;
    logic                  pc_unused;

    assign run       = (state == ST_RUN);
    assign dbg_state = state;
    assign pc_unused = ^{lookup_pc[31:PHT_BITS+2], lookup_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;

    assign lookup_idx = lookup_pc[PHT_BITS+1:2] ^ PHT_BITS'(ghr);

    always_ff @(posedge clk) begin
        if (!rstn)
            ghr <= '0;
        else if (run && update)
            ghr <= GHR_BITS'({ghr, taken});
    end
`else
    localparam int unused_ghr_bits = GHR_BITS;

    assign lookup_idx = lookup_pc[PHT_BITS+1:2];
`endif

    // INIT sweeps every entry to WNT; RUN serves lookups and training until reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_INIT;
            ptr        <= '0;
            ready      <= 1'b0;
            pred_valid <= 1'b0;
            pred_idx   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    pred_valid <= 1'b0;
                    ptr        <= ptr + 1'b1;
                    if (ptr == '1) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    pred_valid <= lookup_en;
                    if (lookup_en)
                        pred_idx <= lookup_idx;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign prediction = rd_ctr[1];

    bp_pht #(.PHT_BITS(PHT_BITS)) u_pht (
        .clk      (clk),
        .rstn     (rstn),
        .rd_en    (run & lookup_en),
        .rd_idx   (lookup_idx),
        .rd_data  (rd_ctr),
        .wr_en    (~run | update),
        .wr_init  (~run),
        .wr_idx   (run ? update_idx : ptr),
        .wr_taken (taken)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor (PHT_BITS=4, GHR_BITS=4); works for both the bimodal
// and the BP_GSHARE_EN build.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  localparam int PB = 4;
  localparam int GB = 4;
  localparam int W  = 3 + PB;
`ifdef BP_GSHARE_EN
  localparam bit GSHARE = 1'b1;
`else
  localparam bit GSHARE = 1'b0;
`endif

  logic          clk;
  logic          rstn;
  logic          ready;
  logic          lookup_en;
  logic [31:0]   lookup_pc;
  logic          pred_valid;
  logic          prediction;
  logic [PB-1:0] pred_idx;
  logic          update;
  logic          taken;
  logic [PB-1:0] update_idx;
  bp_state_t     dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: {ready, pred_valid, prediction, pred_idx} expected after each posedge
  logic [W-1:0] exp_q[$];

  // reference model
  logic [1:0]    m_ctr[16];
  logic [GB-1:0] m_ghr;
  int            m_sweep;
  logic          m_pred;
  logic [PB-1:0] m_idx;

  branch_predictor #(.PHT_BITS(PB), .GHR_BITS(GB)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ready      (ready),
    .lookup_en  (lookup_en),
    .lookup_pc  (lookup_pc),
    .pred_valid (pred_valid),
    .prediction (prediction),
    .pred_idx   (pred_idx),
    .update     (update),
    .taken      (taken),
    .update_idx (update_idx),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_next(logic [1:0] c, logic t);
    if (t) return (c == 2'd3) ? c : c + 2'd1;
    else   return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  function automatic logic [PB-1:0] model_idx(logic [31:0] pc);
    return pc[PB+1:2] ^ (GSHARE ? m_ghr : '0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 2'b01;
    m_ghr   = '0;
    m_sweep = 16;
    m_pred  = 1'b0;
    m_idx   = '0;
  endtask

  // Called at a negedge: drive one cycle of inputs, push its expected result,
  // and return at the following negedge.
  task automatic drive(input logic le, input logic [31:0] pc, input logic up,
                       input logic tk, input logic [PB-1:0] uidx);
    logic [PB-1:0] li;
    logic          vld;
    lookup_en  = le;
    lookup_pc  = pc;
    update     = up;
    taken      = tk;
    update_idx = uidx;
    li  = model_idx(pc);
    vld = 1'b0;
    if (m_sweep == 0) begin
      vld = le;
      if (le) begin
        m_pred = m_ctr[li][1];
        m_idx  = li;
      end
      if (up) begin
        m_ctr[uidx] = model_next(m_ctr[uidx], tk);
        m_ghr = {m_ghr[GB-2:0], tk};
      end
    end else begin
      m_sweep--;
    end
    exp_q.push_back({(m_sweep == 0), vld, m_pred, m_idx});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset(input int hold);
    rstn      = 1'b0;
    lookup_en = 1'b0;
    update    = 1'b0;
    repeat (hold) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_pred_valid", pred_valid, 0);
    check("rst_prediction", prediction, 0);
    check("rst_pred_idx", pred_idx, 0);
    model_reset();
    rstn = 1'b1;
  endtask

  task automatic lookup_all();
    for (int i = 0; i < 16; i++) drive(1'b1, 32'(i * 4), 1'b0, 1'b0, '0);
  endtask

  // scoreboard compare, 1 time unit after each active edge
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ready", ready, e[W-1]);
      check("pred_valid", pred_valid, e[W-2]);
      check("prediction", prediction, e[W-3]);
      check("pred_idx", pred_idx, e[PB-1:0]);
    end
  end

  // main stimulus
  initial begin
    int cnt;
    rstn       = 1'b0;
    lookup_en  = 1'b0;
    lookup_pc  = '0;
    update     = 1'b0;
    taken      = 1'b0;
    update_idx = '0;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // sweep: lookups and updates issued during INIT must be ignored
    drive(1'b1, 32'h40, 1'b0, 1'b0, '0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd3);
    drive(1'b1, 32'h14, 1'b1, 1'b1, 4'd5);
    cnt = 3;
    while (!ready && cnt < 40) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd15);
      cnt++;
    end
    check("ready_latency", cnt, 16);
    lookup_all();

    // saturating training on index 5, back-to-back updates
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd5);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd5);
    drive(1'b1, 32'h14, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd5);
    drive(1'b1, 32'h14, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd5);
    drive(1'b1, 32'h14, 1'b0, 1'b0, '0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd5);
    drive(1'b1, 32'h14, 1'b0, 1'b0, '0);

    // same-cycle lookup and update to one index: read-first
    do_reset(2);
    idle(16);
    drive(1'b1, 32'h14, 1'b1, 1'b1, model_idx(32'h14));
    drive(1'b1, 32'h14, 1'b0, 1'b0, '0);
    idle(2);

    // history: taken, taken, not-taken then lookup pc 0x4
    do_reset(2);
    idle(16);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    drive(1'b1, 32'h4, 1'b0, 1'b0, '0);
    idle(2);

    // random traffic
    for (int i = 0; i < 120; i++)
      drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            PB'($urandom_range(0, 15)));

    // reset mid-sweep after training restarts the sweep from entry 0
    for (int i = 0; i < 6; i++) drive(1'b0, 32'h0, 1'b1, 1'b1, PB'(i));
    do_reset(2);
    idle(7);
    do_reset(1);
    drive(1'b1, 32'h8, 1'b1, 1'b1, 4'd2);
    idle(15);
    lookup_all();
    idle(1);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
